branch_cond_unit: RTL and testbench



---
 rtl/branch_cond_unit.sv | 87 ++++++++
 tb/tb_branch_cond_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: resolves branch conditions from ALU flags with a bounded flag wait and saturating statistics
module branch_cond_unit #(
    parameter int CTRL_W  = 3,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eval_req,
    input  logic [CTRL_W-1:0] branch_ctrl,
    input  logic              flag_valid,
    input  logic              alu_zero,
    input  logic              alu_gt,
    input  logic              alu_lt,
    input  logic              flush,
    output logic              pc_write_cond,
    output logic              cond_result,
    output logic              done,
    output logic              busy,
    output logic              timeout_err,
    output logic [CNT_W-1:0]  taken_count,
    output logic [CNT_W-1:0]  resolve_count
);
    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, RESOLVE} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              zero_q, zero_d, gt_q, gt_d, lt_q, lt_d;
    logic [7:0]        wait_q, wait_d;
    logic              cond_q, cond_d, tmo_q, tmo_d;
    logic [CNT_W-1:0]  taken_q, taken_d, res_q, res_d;
    logic [7:0]        cond_vec;
    logic              taken, resolve_ok, timeout_hit, latch_sel, latch_flags;
    always_comb begin
        cond_vec    = {gt_q | zero_q, lt_q, 1'b1, 1'b0, gt_q | lt_q, lt_q | zero_q, gt_q, zero_q};
        taken       = ((ctrl_q >> 3) == '0) && cond_vec[ctrl_q[2:0]];
        resolve_ok  = (state_q == RESOLVE) && !flush;
        timeout_hit = (state_q == WAIT_FLAGS) && !flag_valid && !flush && (wait_q == TO_LAST);
        latch_sel   = (state_q == IDLE) && eval_req && !flush;
        latch_flags = !flush && flag_valid && (latch_sel || state_q == WAIT_FLAGS);
        state_d     = flush ? IDLE :
                      (state_q == IDLE)       ? (eval_req ? (flag_valid ? RESOLVE : WAIT_FLAGS) : IDLE) :
                      (state_q == WAIT_FLAGS) ? (flag_valid ? RESOLVE : timeout_hit ? IDLE : WAIT_FLAGS) :
                      IDLE;
        ctrl_d      = latch_sel ? branch_ctrl : ctrl_q;
        zero_d      = latch_flags ? alu_zero : zero_q;
        gt_d        = latch_flags ? alu_gt : gt_q;
        lt_d        = latch_flags ? alu_lt : lt_q;
        wait_d      = (state_q == WAIT_FLAGS) ? wait_q + 8'd1 : 8'd0;
        cond_d      = resolve_ok ? taken : cond_q;
        tmo_d       = timeout_hit;
        taken_d     = (resolve_ok && taken && !(&taken_q)) ? taken_q + CNT_W'(1) : taken_q;
        res_d       = (resolve_ok && !(&res_q)) ? res_q + CNT_W'(1) : res_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            zero_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            wait_q  <= '0;
            cond_q  <= 1'b0;
            tmo_q   <= 1'b0;
            taken_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            zero_q  <= zero_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            wait_q  <= wait_d;
            cond_q  <= cond_d;
            tmo_q   <= tmo_d;
            taken_q <= taken_d;
            res_q   <= res_d;
        end
    end
    assign pc_write_cond = resolve_ok && taken;
    assign done          = resolve_ok;
    assign busy          = state_q != IDLE;
    assign cond_result   = cond_q;
    assign timeout_err   = tmo_q;
    assign taken_count   = taken_q;
    assign resolve_count = res_q;
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed vector table plus hand-written multi-cycle sequences for branch_cond_unit
module tb_branch_cond_unit;
    logic       clk = 0, reset_n = 0, eval_req = 0, flag_valid = 0;
    logic       alu_zero = 0, alu_gt = 0, alu_lt = 0, flush = 0;
    logic [3:0] branch_ctrl = 0;
    logic       pc_write_cond, cond_result, done, busy, timeout_err;
    logic [1:0] taken_count, resolve_count;
    int         checks = 0, errors = 0;
    logic [1:0] exp_tk = 0, exp_rs = 0;
    logic       exp_cr = 0;
    typedef struct {
        logic [3:0] ctrl;
        logic       z, g, l, exp;
    } vec_t;
    vec_t       vt[18];
    logic [1:0] tk_seq[4];

    branch_cond_unit #(.CTRL_W(4), .CNT_W(2), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .eval_req(eval_req), .branch_ctrl(branch_ctrl),
        .flag_valid(flag_valid), .alu_zero(alu_zero), .alu_gt(alu_gt), .alu_lt(alu_lt),
        .flush(flush), .pc_write_cond(pc_write_cond), .cond_result(cond_result), .done(done),
        .busy(busy), .timeout_err(timeout_err), .taken_count(taken_count), .resolve_count(resolve_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sat(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    task automatic drive(input logic e, input logic f, input logic [3:0] c,
                         input logic z, input logic g, input logic l, input logic fl);
        eval_req = e; flag_valid = f; branch_ctrl = c;
        alu_zero = z; alu_gt = g; alu_lt = l; flush = fl;
        #1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_cond_result"}, cond_result, exp_cr);
        chk({tag, "_taken_count"}, taken_count, exp_tk);
        chk({tag, "_resolve_count"}, resolve_count, exp_rs);
    endtask

    task automatic do_reset;
        reset_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pc", pc_write_cond, 0);
        chk("rst_tmo", timeout_err, 0);
        exp_tk = 0; exp_rs = 0; exp_cr = 0;
        chk_stats("rst");
        tick;
        reset_n = 1;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] c,
                           input logic z, input logic g, input logic l, input logic exp);
        drive(1, 1, c, z, g, l, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk({tag, "_pc"}, pc_write_cond, exp);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 1);
        tick;
        exp_rs = sat(exp_rs);
        if (exp) exp_tk = sat(exp_tk);
        exp_cr = exp;
        chk({tag, "_idle"}, busy, 0);
        chk_stats(tag);
    endtask

    initial begin
        vt[0]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{4'd1,  1'b0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{4'd2,  1'b0, 1'b0, 1'b1, 1'b1};
        vt[5]  = '{4'd2,  1'b1, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{4'd3,  1'b0, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{4'd3,  1'b0, 1'b0, 1'b1, 1'b1};
        vt[9]  = '{4'd3,  1'b1, 1'b0, 1'b0, 1'b0};
        vt[10] = '{4'd4,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b1};
        vt[12] = '{4'd6,  1'b0, 1'b0, 1'b1, 1'b1};
        vt[13] = '{4'd6,  1'b1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{4'd7,  1'b1, 1'b0, 1'b0, 1'b1};
        vt[15] = '{4'd7,  1'b0, 1'b0, 1'b1, 1'b0};
        vt[16] = '{4'd8,  1'b1, 1'b1, 1'b1, 1'b0};
        vt[17] = '{4'd15, 1'b1, 1'b0, 1'b0, 1'b0};
        tk_seq = '{2'd1, 2'd2, 2'd3, 2'd3};

        do_reset;
        for (int k = 0; k < 4; k++) begin
            run_vec($sformatf("sat%0d", k), 4'd5, 0, 0, 0, 1);
            chk($sformatf("sat%0d_seq", k), taken_count, tk_seq[k]);
        end

        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) do_reset;
            run_vec($sformatf("vec%0d", i), vt[i].ctrl, vt[i].z, vt[i].g, vt[i].l, vt[i].exp);
        end

        // late flags, not-taken resolution after a taken one
        run_vec("pre", 4'd5, 0, 0, 0, 1);
        drive(1, 0, 3, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_busy1", busy, 1);
        chk("late_done1", done, 0);
        tick;
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("late_busy2", busy, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("late_done", done, 1);
        chk("late_pc", pc_write_cond, 0);
        chk("late_busy3", busy, 1);
        tick;
        exp_rs = sat(exp_rs); exp_cr = 0;
        chk("late_idle", busy, 0);
        chk_stats("late");

        // timeout after 4 waiting cycles
        do_reset;
        drive(1, 0, 5, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("to_busy%0d", j), busy, 1);
            chk($sformatf("to_done%0d", j), done, 0);
            chk($sformatf("to_err%0d", j), timeout_err, 0);
            tick;
        end
        chk("to_err", timeout_err, 1);
        chk("to_idle", busy, 0);
        chk("to_done", done, 0);
        tick;
        chk("to_err_clr", timeout_err, 0);
        chk_stats("to");

        // flag_valid on the timeout cycle wins
        drive(1, 0, 7, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        tick;
        drive(0, 1, 0, 1, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("race_done", done, 1);
        chk("race_pc", pc_write_cond, 1);
        chk("race_busy", busy, 1);
        chk("race_err", timeout_err, 0);
        tick;
        exp_rs = sat(exp_rs); exp_tk = sat(exp_tk); exp_cr = 1;
        chk("race_err2", timeout_err, 0);
        chk_stats("race");

        // flush during RESOLVE of a taken branch
        do_reset;
        drive(1, 1, 5, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("fl_pc", pc_write_cond, 0);
        chk("fl_done", done, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fl_idle", busy, 0);
        chk_stats("fl");

        // flush with eval_req in IDLE
        drive(1, 1, 5, 0, 0, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fe_busy", busy, 0);
        chk("fe_done", done, 0);
        tick;
        chk_stats("fe");

        // eval_req while busy is ignored
        drive(1, 0, 4, 0, 0, 0, 0);
        tick;
        drive(1, 1, 5, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("ig_pc", pc_write_cond, 0);
        chk("ig_done", done, 1);
        tick;
        exp_rs = sat(exp_rs); exp_cr = 0;
        chk("ig_busy", busy, 0);
        chk("ig_done2", done, 0);
        chk_stats("ig");

        // flush in WAIT_FLAGS beats flag_valid
        drive(1, 0, 5, 0, 0, 0, 0);
        tick;
        drive(0, 1, 0, 1, 1, 1, 1);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("fw_busy", busy, 0);
        chk("fw_done", done, 0);
        chk_stats("fw");

        // reset in WAIT_FLAGS, then a normal resolution
        drive(1, 0, 5, 0, 0, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rw_busy", busy, 1);
        do_reset;
        run_vec("post", 4'd0, 1, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
